// File: rtl/fpga_ram_mrnw_lvt_if.sv
// Read/write port bundle for fpga_ram_mrnw_lvt: NR async read ports, NW write ports, init status.
interface fpga_ram_mrnw_lvt_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int NR    = 7,
  parameter int NW    = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NR-1:0][AW-1:0]    raddr;
  logic [NR-1:0][WIDTH-1:0] rdata;
  logic [NW-1:0]            we;
  logic [NW-1:0][AW-1:0]    waddr;
  logic [NW-1:0][WIDTH-1:0] wdata;
  logic                     init_done;

  modport master (output raddr, we, waddr, wdata, input rdata, init_done);
  modport slave  (input raddr, we, waddr, wdata, output rdata, init_done);
endinterface

// File: rtl/fpga_ram_mrnw_lvt.sv
// Multi-read / multi-write LUTRAM register file: NW x NR banks steered by a live-value table,
// self-clearing after reset. Define FPGA_RAM_WR_BYPASS_EN for write-first read behaviour.
module fpga_ram_mrnw_lvt #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int NR    = 7,
  parameter int NW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  fpga_ram_mrnw_lvt_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] cnt, cnt_next;

  logic [WIDTH-1:0] bank [NW][NR][DEPTH];
  logic [LW-1:0]    lvt  [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == INIT) begin
      if (cnt == AW'(DEPTH - 1)) state_next = RUN;
      else                        cnt_next   = cnt + 1'b1;
    end
  end

  // Storage has no reset: the INIT sweep clears one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      lvt[cnt] <= '0;
      for (int unsigned w = 0; w < NW; w++)
        for (int unsigned r = 0; r < NR; r++)
          bank[w][r][cnt] <= '0;
    end else begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (bus.we[w]) begin
          lvt[bus.waddr[w]] <= LW'(w);
          for (int unsigned r = 0; r < NR; r++)
            bank[w][r][bus.waddr[w]] <= bus.wdata[w];
        end
      end
    end
  end

  assign bus.init_done = (state == RUN);

  always_comb begin
    bus.rdata = '0;
    if (state == RUN) begin
      for (int unsigned r = 0; r < NR; r++) begin
        bus.rdata[r] = bank[lvt[bus.raddr[r]]][r][bus.raddr[r]];
`ifdef FPGA_RAM_WR_BYPASS_EN
        for (int unsigned w = 0; w < NW; w++)
          if (bus.we[w] && (bus.waddr[w] == bus.raddr[r]))
            bus.rdata[r] = bus.wdata[w];
`endif
      end
    end
  end
endmodule

// File: tb/tb_fpga_ram_mrnw_lvt.sv
// Randomised and directed bench for fpga_ram_mrnw_lvt against a flat-array reference model.
module tb_fpga_ram_mrnw_lvt;
  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int NR    = 7;
  localparam int NW    = 2;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpga_ram_mrnw_lvt_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus ();
  fpga_ram_mrnw_lvt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: one flat array holding the architecturally visible value per address.
  logic [WIDTH-1:0] model [DEPTH];
  bit               running = 1'b0;

  function automatic logic [WIDTH-1:0] exp_rd(int r);
    logic [WIDTH-1:0] v;
    if (!running) return '0;
    v = model[bus.raddr[r]];
`ifdef FPGA_RAM_WR_BYPASS_EN
    for (int w = 0; w < NW; w++)
      if (bus.we[w] && bus.waddr[w] == bus.raddr[r]) v = bus.wdata[w];
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (running)
      for (int w = 0; w < NW; w++)
        if (bus.we[w]) model[bus.waddr[w]] = bus.wdata[w];
    @(negedge clk);
  endtask

  task automatic set_raddr_all(input int a);
    for (int r = 0; r < NR; r++) bus.raddr[r] = AW'(a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.we = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.init_done !== 1'b0 || bus.rdata !== '0) begin
      failures++;
      $display("FAIL reset_hold init_done=%b rdata_nonzero=%b", bus.init_done, bus.rdata !== '0);
    end
    rst = 1'b0;
    running = 1'b0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
  endtask

  // Random traffic during INIT (all of it must be ignored); counts cycles until init_done.
  task automatic wait_init(input int inj_cyc);
    int cyc = 1;
    bit done = 1'b0;
    while (!done) begin
      bus.we = NW'($urandom);
      for (int w = 0; w < NW; w++) begin
        bus.waddr[w] = AW'($urandom_range(0, DEPTH - 1));
        bus.wdata[w] = WIDTH'($urandom);
      end
      for (int r = 0; r < NR; r++) bus.raddr[r] = AW'($urandom_range(0, DEPTH - 1));
      if (cyc == inj_cyc) begin
        bus.we = '0;
        bus.we[0] = 1'b1;
        bus.waddr[0] = AW'(3);
        bus.wdata[0] = 32'h0000_00FF;
      end
      #1;
      if (bus.init_done === 1'b1) done = 1'b1;
      else begin
        checks++;
        if (bus.rdata !== '0) begin
          failures++;
          $display("FAIL init_rdata cycle=%0d got=%h exp=0", cyc, bus.rdata);
        end
        if (cyc >= 200) begin
          failures++;
          $display("FAIL init_timeout cycles=%0d", cyc);
          done = 1'b1;
        end else begin
          tick();
          cyc++;
        end
      end
    end
    checks++;
    if (cyc != DEPTH + 1) begin
      failures++;
      $display("FAIL init_latency got=%0d exp=%0d", cyc, DEPTH + 1);
    end
    bus.we = '0;
    running = 1'b1;
  endtask

  task automatic test_reset();
    bus.we = '0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.raddr = '0;
    do_reset();
    wait_init(-1);
  endtask

  task automatic test_single_write();
    bus.we = '0;
    bus.we[0] = 1'b1;
    bus.waddr[0] = AW'(5);
    bus.wdata[0] = 32'hA5A5_0001;
    tick();
    bus.we = '0;
    set_raddr_all(5);
    #1;
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (bus.rdata[r] !== 32'hA5A5_0001) begin
        failures++;
        $display("FAIL single_write port=%0d got=%h exp=a5a50001", r, bus.rdata[r]);
      end
    end
  endtask

  task automatic test_multi_write();
    bus.we = '1;
    bus.waddr[0] = AW'(9);
    bus.wdata[0] = 32'h0000_1111;
    bus.waddr[1] = AW'(9);
    bus.wdata[1] = 32'h0000_2222;
    tick();
    bus.we = '0;
    set_raddr_all(9);
    #1;
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (bus.rdata[r] !== 32'h0000_2222) begin
        failures++;
        $display("FAIL same_addr_priority port=%0d got=%h exp=00002222", r, bus.rdata[r]);
      end
    end
    bus.we[0] = 1'b1;
    bus.wdata[0] = 32'h0000_3333;
    tick();
    bus.we = '0;
    #1;
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (bus.rdata[r] !== 32'h0000_3333) begin
        failures++;
        $display("FAIL lvt_switch_back port=%0d got=%h exp=00003333", r, bus.rdata[r]);
      end
    end
  endtask

  task automatic test_init_write();
    do_reset();
    wait_init(10);
    set_raddr_all(3);
    #1;
    checks++;
    if (bus.rdata[0] !== '0 || bus.rdata[NR-1] !== '0) begin
      failures++;
      $display("FAIL init_write_ignored got=%h/%h exp=0", bus.rdata[0], bus.rdata[NR-1]);
    end
  endtask

  task automatic test_mid_init_reset();
    bus.we = '0;
    bus.we[1] = 1'b1;
    bus.waddr[1] = AW'(20);
    bus.wdata[1] = 32'hDEAD_0020;
    tick();
    bus.we = '0;
    set_raddr_all(20);
    #1;
    checks++;
    if (bus.rdata[3] !== 32'hDEAD_0020) begin
      failures++;
      $display("FAIL pre_reset_write got=%h exp=dead0020", bus.rdata[3]);
    end
    do_reset();
    repeat (30) tick();
    do_reset();
    wait_init(-1);
    for (int k = 0; k < 3; k++) begin
      set_raddr_all(k == 0 ? 20 : (k == 1 ? 5 : 9));
      #1;
      for (int r = 0; r < NR; r++) begin
        checks++;
        if (bus.rdata[r] !== '0) begin
          failures++;
          $display("FAIL cleared_after_reset addr=%0d port=%0d got=%h exp=0", bus.raddr[r], r, bus.rdata[r]);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] exp_same;
    bus.we = '0;
    bus.we[0] = 1'b1;
    bus.waddr[0] = AW'(7);
    bus.wdata[0] = 32'h0000_1234;
    tick();
    bus.wdata[0] = 32'h0000_BEEF;
    set_raddr_all(7);
`ifdef FPGA_RAM_WR_BYPASS_EN
    exp_same = 32'h0000_BEEF;
`else
    exp_same = 32'h0000_1234;
`endif
    #1;
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (bus.rdata[r] !== exp_same) begin
        failures++;
        $display("FAIL same_cycle_read port=%0d got=%h exp=%h", r, bus.rdata[r], exp_same);
      end
    end
    tick();
    bus.we = '0;
    #1;
    checks++;
    if (bus.rdata[2] !== 32'h0000_BEEF) begin
      failures++;
      $display("FAIL next_cycle_read got=%h exp=0000beef", bus.rdata[2]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      bus.we = NW'($urandom);
      for (int w = 0; w < NW; w++) begin
        bus.waddr[w] = AW'((n < 250) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
        bus.wdata[w] = WIDTH'($urandom);
      end
      for (int r = 0; r < NR; r++)
        bus.raddr[r] = AW'((n < 250) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1));
      #1;
      for (int r = 0; r < NR; r++) begin
        checks++;
        if (bus.rdata[r] !== exp_rd(r)) begin
          failures++;
          $display("FAIL random_read iter=%0d port=%0d addr=%0d got=%h exp=%h",
                   n, r, bus.raddr[r], bus.rdata[r], exp_rd(r));
        end
      end
      if (n % 50 == 0) begin
        checks++;
        if (bus.init_done !== 1'b1) begin
          failures++;
          $display("FAIL run_init_done iter=%0d got=%b exp=1", n, bus.init_done);
        end
      end
      tick();
    end
    bus.we = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_multi_write();
    test_init_write();
    test_mid_init_reset();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
